// File: rtl/dmux_router_if.sv
// Handshake bundle between one producer, the router and NOUT consumers.
// The router takes the slave modport; the environment driving it takes master.
interface dmux_router_if #(
    parameter int WIDTH = 16,
    parameter int NOUT  = 4,
    parameter int SELW  = 2
);
    logic [WIDTH-1:0]      in_data;
    logic [SELW-1:0]       in_sel;
    logic                  in_bcast;
    logic                  in_valid;
    logic                  in_ready;
    logic [NOUT*WIDTH-1:0] out_data;
    logic [NOUT-1:0]       out_valid;
    logic [NOUT-1:0]       out_ready;
    logic [7:0]            err_count;

    modport master (
        output in_data, in_sel, in_bcast, in_valid, out_ready,
        input  in_ready, out_data, out_valid, err_count
    );

    modport slave (
        input  in_data, in_sel, in_bcast, in_valid, out_ready,
        output in_ready, out_data, out_valid, err_count
    );
endinterface

// File: rtl/dmux_router.sv
// Registered 1-to-NOUT demultiplexer with a one-word buffer per channel,
// broadcast delivery and a saturating count of out-of-range selects.
module dmux_router #(
    parameter int WIDTH = 16,
    parameter int NOUT  = 4,
    parameter int SELW  = 2
) (
    input  logic           clk,
    input  logic           reset,
    dmux_router_if.slave   bus
);
    logic [NOUT*WIDTH-1:0] data_r;
    logic [NOUT-1:0]       valid_r;
    logic [7:0]            err_r;

    logic [NOUT-1:0]       free_s;
    logic [NOUT-1:0]       target_s;
    logic [NOUT-1:0]       load_s;
    logic                  sel_ok_s;
    logic                  ready_s;
    logic                  accept_s;
    logic                  drop_s;

    // Channel freedom, destination decode and the combinational in_ready.
    always_comb begin
        free_s   = ~valid_r | bus.out_ready;
        sel_ok_s = (int'(bus.in_sel) < NOUT);
        target_s = '0;
        if (bus.in_bcast) begin
            target_s = '1;
        end else begin
            for (int k = 0; k < NOUT; k++) begin
                target_s[k] = sel_ok_s && (int'(bus.in_sel) == k);
            end
        end
        // A broadcast needs every buffer free so all channels load together.
        if (bus.in_bcast) begin
            ready_s = &free_s;
        end else if (sel_ok_s) begin
            ready_s = |(target_s & free_s);
        end else begin
            ready_s = 1'b1;
        end
        accept_s = bus.in_valid && ready_s;
        drop_s   = accept_s && !bus.in_bcast && !sel_ok_s;
        load_s   = target_s & {NOUT{accept_s}};
    end

    // Per-channel buffers: load wins over drain so a drain+reload stays valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_r  <= '0;
            valid_r <= '0;
        end else begin
            for (int k = 0; k < NOUT; k++) begin
                if (load_s[k]) begin
                    data_r[k*WIDTH +: WIDTH] <= bus.in_data;
                    valid_r[k]               <= 1'b1;
                end else if (bus.out_ready[k]) begin
                    valid_r[k] <= 1'b0;
                end else begin
                    valid_r[k] <= valid_r[k];
                end
            end
        end
    end

    // Saturating discard counter for out-of-range unicast selects.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_r <= 8'd0;
        end else if (drop_s && (err_r != 8'hFF)) begin
            err_r <= err_r + 8'd1;
        end else begin
            err_r <= err_r;
        end
    end

    assign bus.in_ready  = ready_s;
    assign bus.out_data  = data_r;
    assign bus.out_valid = valid_r;
    assign bus.err_count = err_r;
endmodule

// File: tb/tb_dmux_router.sv
// Self-checking bench: two routers (4 and 3 channels) against a queue-based
// model of the routing rules, plus literal checks from the directed scenarios.
module tb_dmux_router;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    dmux_router_if #(.WIDTH(16), .NOUT(4), .SELW(2)) ifa ();
    dmux_router_if #(.WIDTH(16), .NOUT(3), .SELW(2)) ifb ();

    dmux_router #(.WIDTH(16), .NOUT(4), .SELW(2)) u_a (.clk(clk), .reset(reset), .bus(ifa));
    dmux_router #(.WIDTH(16), .NOUT(3), .SELW(2)) u_b (.clk(clk), .reset(reset), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stimulus for both routers, index 0 = 4-channel, 1 = 3-channel
    logic [15:0] i_data [2];
    int          i_sel  [2];
    logic        i_bcast[2];
    logic        i_valid[2];
    logic [3:0]  i_ordy [2];

    // model: each channel is a queue of at most one word; mlast is what the
    // output bus shows (last loaded word, zero after reset)
    logic [15:0] mq [8][$];
    logic [15:0] mlast [8];
    int          merr [2];

    function automatic int nout(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic apply();
        ifa.in_data   = i_data[0];
        ifa.in_sel    = 2'(i_sel[0]);
        ifa.in_bcast  = i_bcast[0];
        ifa.in_valid  = i_valid[0];
        ifa.out_ready = i_ordy[0];
        ifb.in_data   = i_data[1];
        ifb.in_sel    = 2'(i_sel[1]);
        ifb.in_bcast  = i_bcast[1];
        ifb.in_valid  = i_valid[1];
        ifb.out_ready = i_ordy[1][2:0];
    endtask

    task automatic get(input int d, output logic rdy, output logic [3:0] ov,
                       output logic [63:0] od, output logic [7:0] ec);
        if (d == 0) begin
            rdy = ifa.in_ready;
            ov  = ifa.out_valid;
            od  = 64'(ifa.out_data);
            ec  = ifa.err_count;
        end else begin
            rdy = ifb.in_ready;
            ov  = {1'b0, ifb.out_valid};
            od  = 64'(ifb.out_data);
            ec  = ifb.err_count;
        end
    endtask

    function automatic logic [63:0] chan(input int d, input int k);
        logic [63:0] od;
        od = (d == 0) ? 64'(ifa.out_data) : 64'(ifb.out_data);
        return (od >> (k * 16)) & 64'hFFFF;
    endfunction

    function automatic logic exp_ready(input int d);
        logic r;
        if (i_bcast[d]) begin
            r = 1'b1;
            for (int k = 0; k < nout(d); k++)
                if (mq[d*4+k].size() != 0 && !i_ordy[d][k]) r = 1'b0;
        end else if (i_sel[d] < nout(d)) begin
            r = (mq[d*4+i_sel[d]].size() == 0) || i_ordy[d][i_sel[d]];
        end else begin
            r = 1'b1;
        end
        return r;
    endfunction

    task automatic check(input int d);
        logic        rdy;
        logic [3:0]  ov;
        logic [63:0] od;
        logic [7:0]  ec;
        logic [3:0]  eov;
        get(d, rdy, ov, od, ec);
        eov = 4'b0000;
        for (int k = 0; k < nout(d); k++) begin
            eov[k] = (mq[d*4+k].size() != 0);
            chk($sformatf("out_data[%0d][%0d]", d, k), (od >> (k * 16)) & 64'hFFFF, 64'(mlast[d*4+k]));
        end
        chk($sformatf("in_ready[%0d]", d), 64'(rdy), 64'(exp_ready(d)));
        chk($sformatf("out_valid[%0d]", d), 64'(ov), 64'(eov));
        chk($sformatf("err_count[%0d]", d), 64'(ec), 64'(merr[d]));
    endtask

    task automatic update(input int d);
        logic acc;
        acc = i_valid[d] && exp_ready(d);
        for (int k = 0; k < nout(d); k++)
            if (i_ordy[d][k] && mq[d*4+k].size() != 0) void'(mq[d*4+k].pop_front());
        if (acc) begin
            if (i_bcast[d]) begin
                for (int k = 0; k < nout(d); k++) begin
                    mq[d*4+k].push_back(i_data[d]);
                    mlast[d*4+k] = i_data[d];
                end
            end else if (i_sel[d] < nout(d)) begin
                mq[d*4+i_sel[d]].push_back(i_data[d]);
                mlast[d*4+i_sel[d]] = i_data[d];
            end else if (merr[d] < 255) begin
                merr[d] = merr[d] + 1;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            mq[i].delete();
            mlast[i] = 16'h0000;
        end
        merr[0] = 0;
        merr[1] = 0;
    endtask

    // one clock: check at the falling edge, advance the model, step past the rising edge
    task automatic cycle();
        apply();
        @(negedge clk);
        check(0);
        check(1);
        update(0);
        update(1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d);
        i_valid[d] = 1'b0;
        i_bcast[d] = 1'b0;
        i_ordy[d]  = 4'b0000;
    endtask

    task automatic set(input int d, input logic [15:0] data, input int sel,
                       input logic bc, input logic [3:0] ordy);
        i_data[d]  = data;
        i_sel[d]   = sel;
        i_bcast[d] = bc;
        i_valid[d] = 1'b1;
        i_ordy[d]  = ordy;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        model_reset();
        for (int d = 0; d < 2; d++) begin
            i_data[d] = 16'h0000;
            i_sel[d]  = 0;
            idle(d);
        end
        reset = 1'b1;
        apply();
        #2;
        chk("reset_in_ready", 64'(ifa.in_ready), 64'd1);
        chk("reset_out_valid", 64'(ifa.out_valid), 64'd0);
        check(0);
        check(1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // unicast A5A5 to channel 2
        set(0, 16'hA5A5, 2, 1'b0, 4'b0000);
        cycle();
        chk("uni_valid", 64'(ifa.out_valid), 64'h4);
        chk("uni_ch2", chan(0, 2), 64'hA5A5);
        chk("uni_ch0", chan(0, 0), 64'h0);
        chk("uni_err", 64'(ifa.err_count), 64'd0);

        // back-pressure on channel 2, then release
        set(0, 16'h1234, 2, 1'b0, 4'b0000);
        apply();
        #1 chk("bp_stall_ready", 64'(ifa.in_ready), 64'd0);
        cycle();
        chk("bp_hold", chan(0, 2), 64'hA5A5);
        i_ordy[0] = 4'b0100;
        apply();
        #1 chk("bp_release_ready", 64'(ifa.in_ready), 64'd1);
        cycle();
        chk("bp_reload", chan(0, 2), 64'h1234);
        chk("bp_valid", 64'(ifa.out_valid[2]), 64'd1);

        // broadcast blocked by stalled channel 1, then released
        set(0, 16'h1111, 1, 1'b0, 4'b0000);
        cycle();
        set(0, 16'hBEEF, 0, 1'b1, 4'b0100);
        apply();
        #1 chk("bc_stall_ready", 64'(ifa.in_ready), 64'd0);
        cycle();
        chk("bc_no_load", chan(0, 1), 64'h1111);
        chk("bc_no_load_valid", 64'(ifa.out_valid), 64'h2);
        set(0, 16'hBEEF, 0, 1'b1, 4'b0110);
        cycle();
        chk("bc_valid", 64'(ifa.out_valid), 64'hF);
        for (int k = 0; k < 4; k++) chk("bc_data", chan(0, k), 64'hBEEF);
        idle(0);
        i_ordy[0] = 4'b1111;
        cycle();

        // out-of-range select on the 3-channel router
        idle(0);
        for (int i = 0; i < 3; i++) begin
            set(1, 16'(i + 16'h0700), 3, 1'b0, 4'b0000);
            apply();
            #1 chk("inv_ready", 64'(ifb.in_ready), 64'd1);
            cycle();
        end
        chk("inv_err3", 64'(ifb.err_count), 64'd3);
        chk("inv_valid", 64'(ifb.out_valid), 64'd0);
        repeat (300) cycle();
        chk("inv_sat", 64'(ifb.err_count), 64'd255);
        idle(1);

        // streaming 1..8 through channel 0
        for (int i = 0; i < 8; i++) begin
            set(0, 16'(i + 1), 0, 1'b0, 4'b0001);
            apply();
            #1 chk("stream_ready", 64'(ifa.in_ready), 64'd1);
            cycle();
            chk("stream_data", chan(0, 0), 64'(i + 1));
            chk("stream_valid", 64'(ifa.out_valid[0]), 64'd1);
        end
        idle(0);

        // randomized traffic on both routers
        for (int n = 0; n < 3000; n++) begin
            for (int d = 0; d < 2; d++) begin
                i_data[d]  = 16'($urandom);
                i_sel[d]   = int'($urandom_range(3, 0));
                i_bcast[d] = ($urandom_range(7, 0) == 0);
                i_valid[d] = ($urandom_range(3, 0) != 0);
                i_ordy[d]  = 4'($urandom);
            end
            cycle();
        end

        // fill everything, then reset between edges
        for (int d = 0; d < 2; d++) begin
            idle(d);
            i_ordy[d] = 4'b1111;
        end
        cycle();
        set(0, 16'h5555, 0, 1'b1, 4'b0000);
        set(1, 16'h6666, 0, 1'b1, 4'b0000);
        cycle();
        idle(0);
        idle(1);
        cycle();
        chk("fill_valid", 64'(ifa.out_valid), 64'hF);
        #2 reset = 1'b1;
        #1;
        chk("areset_valid", 64'(ifa.out_valid), 64'd0);
        chk("areset_data", 64'(ifa.out_data), 64'd0);
        chk("areset_ready", 64'(ifa.in_ready), 64'd1);
        chk("areset_valid_b", 64'(ifb.out_valid), 64'd0);
        chk("areset_err_b", 64'(ifb.err_count), 64'd0);
        model_reset();
        reset = 1'b0;
        set(0, 16'hCAFE, 3, 1'b0, 4'b0000);
        cycle();
        chk("post_reset_valid", 64'(ifa.out_valid), 64'h8);
        chk("post_reset_ch3", chan(0, 3), 64'hCAFE);
        idle(0);
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
